// File: rtl/gx4000_loader_pkg.sv
// Shared types and constants for the GX4000 cartridge loader: FSM states, result codes,
// ROM type codes and header field offsets.
package gx4000_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StPayload,
        StVerify,
        StDone
    } state_e;

    localparam logic [7:0] ERR_NONE     = 8'h00;
    localparam logic [7:0] ERR_HEADER   = 8'h01;
    localparam logic [7:0] ERR_TYPE     = 8'h02;
    localparam logic [7:0] ERR_SIZE     = 8'h03;
    localparam logic [7:0] ERR_CHECKSUM = 8'h04;
    localparam logic [7:0] ERR_PLUS     = 8'h05;
    localparam logic [7:0] ERR_SEQ      = 8'h06;

    localparam logic [7:0] TYPE_STANDARD  = 8'h00;
    localparam logic [7:0] TYPE_ENHANCED  = 8'h01;
    localparam logic [7:0] TYPE_PLUS      = 8'h01;
    localparam logic [7:0] TYPE_PROTECTED = 8'h02;

    localparam int unsigned OFS_TYPE    = 0;
    localparam int unsigned OFS_SIZE_LO = 1;
    localparam int unsigned OFS_SIZE_HI = 2;
    localparam int unsigned OFS_CSUM_LO = 3;
    localparam int unsigned OFS_CSUM_HI = 4;
    localparam int unsigned OFS_VERSION = 5;
    localparam int unsigned OFS_DATE    = 6;
    localparam int unsigned OFS_TITLE   = 10;

    localparam int unsigned CNT_W = 26;

endpackage

// File: rtl/gx4000_cart_loader_if.sv
// ioctl download bus as seen by the cartridge loader; the HPS/ioctl side is the master.
interface gx4000_cart_loader_if #(
    parameter int unsigned ADDR_W = 25
);
    logic              download;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        dout;

    modport master (output download, wr, addr, dout);
    modport slave  (input  download, wr, addr, dout);
endinterface

// File: rtl/gx4000_loader_sum.sv
// Byte-wise payload accumulator: 16-bit additive sum, or CRC-16/CCITT when
// GX4000_LOADER_CRC_EN is defined.
module gx4000_loader_sum (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] sum
);

`ifdef GX4000_LOADER_CRC_EN
    localparam logic [15:0] Init = 16'hFFFF;

    // MSB-first, poly 0x1021, one byte per call
    function automatic logic [15:0] step(input logic [15:0] acc, input logic [7:0] b);
        logic [15:0] c;
        c = acc ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction
`else
    localparam logic [15:0] Init = 16'h0000;

    function automatic logic [15:0] step(input logic [15:0] acc, input logic [7:0] b);
        return acc + {8'h00, b};
    endfunction
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sum <= 16'h0000;
        end else if (clear) begin
            sum <= Init;
        end else if (en) begin
            sum <= step(sum, data);
        end
    end

endmodule

// File: rtl/gx4000_cart_loader.sv
// GX4000 cartridge loader: captures the ROM header from the ioctl stream, checksums the
// payload and posts a one-shot verdict per download. CRC mode: GX4000_LOADER_CRC_EN.
module gx4000_cart_loader
    import gx4000_loader_pkg::*;
#(
    parameter int unsigned HDR_BYTES   = 32,
    parameter int unsigned TITLE_BYTES = 8,
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned MAX_KB      = 512
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     gx4000_mode,
    input  logic                     plus_mode,
    gx4000_cart_loader_if.slave      ioctl,
    output logic                     busy,
    output logic                     done,
    output logic                     rom_valid,
    output logic [7:0]               err_code,
    output logic [7:0]               rom_type,
    output logic [15:0]              rom_size_kb,
    output logic [15:0]              rom_checksum,
    output logic [7:0]               rom_version,
    output logic [31:0]              rom_date,
    output logic [8*TITLE_BYTES-1:0] rom_title,
    output logic [15:0]              payload_sum
);

    localparam logic [15:0] MaxKb = 16'(MAX_KB);

    state_e            state;
    logic              dl_q;
    logic              hdr_ok_q;
    logic              seq_err_q;
    logic [ADDR_W-1:0] next_addr_q;
    logic [CNT_W-1:0]  byte_cnt_q;

    logic       rise, fall, wr_ok, good_wr, bad_wr, hdr_wr, pay_wr, hdr_last;
    logic [7:0] verdict;

    assign rise = ioctl.download & ~dl_q;
    assign fall = ~ioctl.download & dl_q;

    // dl_q keeps a write on the falling-edge cycle in scope
    assign wr_ok    = ioctl.wr && (ioctl.download || dl_q) && !rise && !seq_err_q &&
                      (state == StHeader || state == StPayload);
    assign good_wr  = wr_ok && (ioctl.addr == next_addr_q);
    assign bad_wr   = wr_ok && (ioctl.addr != next_addr_q);
    assign hdr_wr   = good_wr && (state == StHeader);
    assign pay_wr   = good_wr && (state == StPayload);
    assign hdr_last = hdr_wr && (ioctl.addr == ADDR_W'(HDR_BYTES - 1));

    always_comb begin
        verdict = ERR_NONE;
        if (!hdr_ok_q) begin
            verdict = ERR_HEADER;
        end else if (seq_err_q) begin
            verdict = ERR_SEQ;
        end else if (rom_type > TYPE_PROTECTED) begin
            verdict = ERR_TYPE;
        end else if (rom_size_kb == 16'h0000 || rom_size_kb > MaxKb ||
                     byte_cnt_q != {rom_size_kb, 10'd0}) begin
            verdict = ERR_SIZE;
        end else if (payload_sum != rom_checksum) begin
            verdict = ERR_CHECKSUM;
        end else if (rom_type == TYPE_PLUS && !plus_mode && !gx4000_mode) begin
            verdict = ERR_PLUS;
        end
    end

    gx4000_loader_sum u_sum (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .clear   (rise),
        .en      (pay_wr),
        .data    (ioctl.dout),
        .sum     (payload_sum)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= StIdle;
            dl_q         <= 1'b0;
            hdr_ok_q     <= 1'b0;
            seq_err_q    <= 1'b0;
            next_addr_q  <= '0;
            byte_cnt_q   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rom_valid    <= 1'b0;
            err_code     <= 8'h00;
            rom_type     <= 8'h00;
            rom_size_kb  <= 16'h0000;
            rom_checksum <= 16'h0000;
            rom_version  <= 8'h00;
            rom_date     <= 32'h0;
            rom_title    <= '0;
        end else begin
            dl_q <= ioctl.download;
            done <= 1'b0;
            if (rise) begin
                state       <= StHeader;
                busy        <= 1'b1;
                rom_valid   <= 1'b0;
                err_code    <= ERR_NONE;
                hdr_ok_q    <= 1'b0;
                seq_err_q   <= 1'b0;
                next_addr_q <= '0;
                byte_cnt_q  <= '0;
            end else begin
                if (bad_wr) seq_err_q <= 1'b1;
                if (good_wr) next_addr_q <= next_addr_q + 1'b1;
                if (pay_wr && byte_cnt_q != '1) byte_cnt_q <= byte_cnt_q + 1'b1;
                if (hdr_last) hdr_ok_q <= 1'b1;
                if (hdr_wr) begin
                    case (ioctl.addr)
                        ADDR_W'(OFS_TYPE):     rom_type            <= ioctl.dout;
                        ADDR_W'(OFS_SIZE_LO):  rom_size_kb[7:0]    <= ioctl.dout;
                        ADDR_W'(OFS_SIZE_HI):  rom_size_kb[15:8]   <= ioctl.dout;
                        ADDR_W'(OFS_CSUM_LO):  rom_checksum[7:0]   <= ioctl.dout;
                        ADDR_W'(OFS_CSUM_HI):  rom_checksum[15:8]  <= ioctl.dout;
                        ADDR_W'(OFS_VERSION):  rom_version         <= ioctl.dout;
                        ADDR_W'(OFS_DATE):     rom_date[7:0]       <= ioctl.dout;
                        ADDR_W'(OFS_DATE + 1): rom_date[15:8]      <= ioctl.dout;
                        ADDR_W'(OFS_DATE + 2): rom_date[23:16]     <= ioctl.dout;
                        ADDR_W'(OFS_DATE + 3): rom_date[31:24]     <= ioctl.dout;
                        default: ;
                    endcase
                    for (int i = 0; i < int'(TITLE_BYTES); i++) begin
                        if (ioctl.addr == ADDR_W'(OFS_TITLE + i)) rom_title[8*i +: 8] <= ioctl.dout;
                    end
                end
                unique case (state)
                    StHeader: begin
                        if (fall) state <= StVerify;
                        else if (hdr_last) state <= StPayload;
                    end
                    StPayload: begin
                        if (fall) state <= StVerify;
                    end
                    StVerify: begin
                        state     <= StDone;
                        err_code  <= verdict;
                        rom_valid <= (verdict == ERR_NONE);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                    StDone:  state <= StIdle;
                    default: ;
                endcase
            end
        end
    end

endmodule
